// File: rtl/float_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor (default bfloat16) with valid/ready handshakes.
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise truncate and saturate on overflow.
module float_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic [2:0]             flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EW-1:0] SW_E    = EW'(SW);
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CLASS, ALIGN, ADD, NORM, ROUND, OUT} state_t;
    state_t state_q, state_d;

    logic [W-1:0]    a_q, b_q;
    logic            sa_q, sb_q;
    logic [EW-1:0]   ea_q, eb_q;
    logic [MAN_W:0]  ma_q, mb_q;
    logic            sign_q, eff_sub_q, zsign_q, zero_q;
    logic [EW-1:0]   e_q;
    logic [SW-1:0]   mx_q, my_q, m_q;
    logic [SW:0]     acc_q;
    logic [W-1:0]    sum_q;
    logic [2:0]      flags_q;

    // Classification of the captured operands
    logic [EXP_W-1:0] a_exp, b_exp;
    logic             a_all1, b_all1, a_nan, b_nan, a_inf, b_inf, special;
    logic [W-1:0]     spec_res;
    logic [2:0]       spec_flags;

    always_comb begin
        a_exp  = a_q[W-2:MAN_W];
        b_exp  = b_q[W-2:MAN_W];
        a_all1 = &a_exp;
        b_all1 = &b_exp;
        a_nan  = a_all1 & (|a_q[MAN_W-1:0]);
        b_nan  = b_all1 & (|b_q[MAN_W-1:0]);
        a_inf  = a_all1 & ~(|a_q[MAN_W-1:0]);
        b_inf  = b_all1 & ~(|b_q[MAN_W-1:0]);
        special    = a_all1 | b_all1;
        spec_res   = b_q;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
            spec_res   = QNAN;
            spec_flags = 3'b100;
        end else if (a_inf) begin
            spec_res = a_q;
        end
    end

    // Alignment: X is the operand with the larger magnitude
    logic            a_big;
    logic [EW-1:0]   ex, dexp;
    logic [SW-1:0]   x_ext, y_ext, y_al, mask;

    always_comb begin
        a_big = {ea_q, ma_q} >= {eb_q, mb_q};
        ex    = a_big ? ea_q : eb_q;
        dexp  = a_big ? (ea_q - eb_q) : (eb_q - ea_q);
        x_ext = {(a_big ? ma_q : mb_q), 3'b000};
        y_ext = {(a_big ? mb_q : ma_q), 3'b000};
        mask  = ~({SW{1'b1}} << dexp);
        if (dexp >= SW_E) begin
            y_al = {{(SW-1){1'b0}}, |y_ext};
        end else begin
            y_al    = y_ext >> dexp;
            y_al[0] = y_al[0] | (|(y_ext & mask));
        end
    end

    // Normalisation: leading-zero shift is clamped so the exponent never drops below 1
    logic [EW-1:0] lz, lim, sh, e_norm;
    logic [SW-1:0] m_norm;

    always_comb begin
        lz = SW_E;
        for (int unsigned i = 0; i < SW; i++) begin
            if (acc_q[i]) lz = EW'(SW - 1 - i);
        end
        lim    = e_q - EW'(1);
        sh     = (lz < lim) ? lz : lim;
        m_norm = acc_q[SW-1:0] << sh;
        e_norm = e_q - sh;
        if (acc_q[SW]) begin
            m_norm = acc_q[SW:1] | {{(SW-1){1'b0}}, acc_q[0]};
            e_norm = e_q + EW'(1);
        end
    end

    // Rounding and result packing
    logic             inexact, up;
    logic [MAN_W+1:0] mr;
    logic [MAN_W:0]   mant;
    logic [EW-1:0]    er;
    logic [W-1:0]     rnd_res;
    logic [2:0]       rnd_flags;

    always_comb begin
        inexact = |m_q[2:0];
`ifdef FPADD_RNE_EN
        up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
`else
        up = 1'b0;
`endif
        mr = {1'b0, m_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
        if (mr[MAN_W+1]) begin
            mant = mr[MAN_W+1:1];
            er   = e_q + EW'(1);
        end else begin
            mant = mr[MAN_W:0];
            er   = e_q;
        end
        rnd_flags = {2'b00, inexact};
        rnd_res   = {sign_q, (mant[MAN_W] ? er[EXP_W-1:0] : {EXP_W{1'b0}}), mant[MAN_W-1:0]};
        if (zero_q) begin
            rnd_res   = {zsign_q, {(W-1){1'b0}}};
            rnd_flags = '0;
        end else if (er >= EXP_MAX) begin
            rnd_flags = 3'b011;
`ifdef FPADD_RNE_EN
            rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
            rnd_res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CLASS;
            CLASS:   state_d = special ? OUT : ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q <= '0; b_q <= '0;
            sa_q <= 1'b0; sb_q <= 1'b0;
            ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
            sign_q <= 1'b0; eff_sub_q <= 1'b0; zsign_q <= 1'b0; zero_q <= 1'b0;
            e_q <= '0; mx_q <= '0; my_q <= '0; m_q <= '0; acc_q <= '0;
            sum_q <= '0; flags_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= {b[W-1] ^ op_sub, b[W-2:0]};
                end
                CLASS: if (special) begin
                    sum_q   <= spec_res;
                    flags_q <= spec_flags;
                end else begin
                    sa_q <= a_q[W-1];
                    sb_q <= b_q[W-1];
                    ea_q <= (a_exp == '0) ? EW'(1) : {2'b00, a_exp};
                    eb_q <= (b_exp == '0) ? EW'(1) : {2'b00, b_exp};
                    ma_q <= {(a_exp != '0), a_q[MAN_W-1:0]};
                    mb_q <= {(b_exp != '0), b_q[MAN_W-1:0]};
                end
                ALIGN: begin
                    sign_q    <= a_big ? sa_q : sb_q;
                    eff_sub_q <= sa_q ^ sb_q;
                    zsign_q   <= sa_q & sb_q;
                    e_q       <= ex;
                    mx_q      <= x_ext;
                    my_q      <= y_al;
                end
                ADD: acc_q <= eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                                        : ({1'b0, mx_q} + {1'b0, my_q});
                NORM: begin
                    m_q    <= m_norm;
                    e_q    <= e_norm;
                    zero_q <= ~(|acc_q);
                end
                ROUND: begin
                    sum_q   <= rnd_res;
                    flags_q <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign sum       = sum_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_float_addsub_seq.sv
// Scoreboard bench for float_addsub_seq (bfloat16 defaults); honours FPADD_RNE_EN.
module tb_float_addsub_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic [2:0]  flags;

    typedef struct packed {
        logic [15:0] sum;
        logic [2:0]  flags;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;

    float_addsub_seq #(.EXP_W(8), .MAN_W(7)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .flags(flags)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Output monitor: latency on first out_valid, result on handshake
    always @(negedge clock) begin
        if (in_valid && in_ready) acc_cyc = cyc;
        if (out_valid && !ov_prev && sb_q.size() > 0)
            check("latency", 32'(cyc - acc_cyc), 32'(sb_q[0].lat));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_result", 32'(1), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("sum", 32'(sum), 32'(mon_e.sum));
                check("flags", 32'(flags), 32'(mon_e.flags));
            end
        end
        ov_prev = out_valid;
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tbv, input logic top,
                         input logic [15:0] es, input logic [2:0] ef, input int el);
        exp_t e;
        int   n;
        e.sum = es; e.flags = ef; e.lat = 8'(el);
        sb_q.push_back(e);
        a = ta; b = tbv; op_sub = top; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (!in_ready) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clock); #1; n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'(0));
            sb_q.delete();
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_flags", 32'(flags), 32'(0));
        reset = 1'b0;
        @(posedge clock); #1;

        issue(16'h3F80, 16'h3F80, 1'b0, 16'h4000, 3'b000, 6); drain();
        issue(16'h4040, 16'h3F80, 1'b1, 16'h4000, 3'b000, 6); drain();
        issue(16'h3F80, 16'hBF80, 1'b0, 16'h0000, 3'b000, 6); drain();
`ifdef FPADD_RNE_EN
        issue(16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 3'b001, 6); drain();
        issue(16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 3'b011, 6); drain();
        issue(16'h3FFF, 16'h3B80, 1'b0, 16'h4000, 3'b001, 6); drain();
`else
        issue(16'h3F81, 16'h3B80, 1'b0, 16'h3F81, 3'b001, 6); drain();
        issue(16'h7F7F, 16'h7F7F, 1'b0, 16'h7F7F, 3'b011, 6); drain();
        issue(16'h3FFF, 16'h3B80, 1'b0, 16'h3FFF, 3'b001, 6); drain();
`endif
        issue(16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 3'b100, 2); drain();
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000, 6); drain();
        issue(16'h3F81, 16'h3F80, 1'b1, 16'h3C00, 3'b000, 6); drain();
        issue(16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 3'b000, 2); drain();
        issue(16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 3'b000, 2); drain();
        issue(16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 3'b100, 2); drain();
        issue(16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000, 6); drain();
        issue(16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b000, 6); drain();
        issue(16'h0081, 16'h0080, 1'b1, 16'h0001, 3'b000, 6); drain();
        issue(16'h4B80, 16'h3F80, 1'b0, 16'h4B80, 3'b001, 6);
        issue(16'h3F80, 16'hC040, 1'b0, 16'hC000, 3'b000, 6); drain();

        // Consumer back-pressure: result must hold while out_ready is low
        out_ready = 1'b0;
        issue(16'h3F80, 16'h3F80, 1'b0, 16'h4000, 3'b000, 6);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock); #1; n++;
        end
        check("hold_reached", 32'(out_valid), 32'(1));
        repeat (5) begin
            @(negedge clock);
            check("hold_out_valid", 32'(out_valid), 32'(1));
            check("hold_in_ready", 32'(in_ready), 32'(0));
            check("hold_sum", 32'(sum), 32'h4000);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        drain();

        // Reset while in ALIGN discards the operation
        a = 16'h3F80; b = 16'h3F80; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_sum", 32'(sum), 32'(0));
        repeat (10) @(posedge clock);
        #1;
        check("midrst_idle", 32'(in_ready), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
